// File: rtl/ram_copier.sv
// Block-copy / fill engine driving a ram4k-class port (combinational read, write on clk when load).
// Copy moves one word per READ/WRITE pair; fill writes one word per cycle.
module ram_copier #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W-1:0] len,
   input  logic [DATA_W-1:0] fill_val,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_in,
   output logic              mem_load,
   input  logic [DATA_W-1:0] mem_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_src_ptr;
   logic [ADDR_W-1:0] r_dst_ptr;
   logic [ADDR_W-1:0] r_count;
   logic [DATA_W-1:0] r_data;
   logic              r_mode;

   // NOTE: every signal assigned in this block gets a default on the first line,
   // so no path through the case can leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (len == '0)
                  w_state_nxt = S_DONE;
               else if (mode)
                  w_state_nxt = S_WRITE;
               else
                  w_state_nxt = S_READ;
            end
         end
         S_READ:  w_state_nxt = abort ? S_IDLE : S_WRITE;
         S_WRITE: begin
            if (abort)
               w_state_nxt = S_IDLE;
            else if (r_count == ADDR_W'(1))
               w_state_nxt = S_DONE;
            else
               w_state_nxt = r_mode ? S_WRITE : S_READ;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Pointers advance on every WRITE edge, including an aborted one, since that write lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src_ptr <= '0;
         r_dst_ptr <= '0;
         r_count   <= '0;
         r_data    <= '0;
         r_mode    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src_ptr <= src;
                  r_dst_ptr <= dst;
                  r_count   <= len;
                  r_mode    <= mode;
                  if (mode)
                     r_data <= fill_val;
               end
            end
            S_READ:  r_data <= mem_out;
            S_WRITE: begin
               r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
               if (!r_mode)
                  r_src_ptr <= r_src_ptr + ADDR_W'(1);
               r_count <= r_count - ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign mem_address = (r_state == S_READ) ? r_src_ptr : r_dst_ptr;
   assign mem_in      = r_data;
   assign mem_load    = (r_state == S_WRITE);
   assign busy        = (r_state == S_READ) || (r_state == S_WRITE);
   assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_ram_copier.sv
// Directed bench for ram_copier: a ram4k behavioural model plus hand-computed expectations
// for copy, wrapping fill, len=0, start-while-busy, abort, overlap and async reset.
module tb_ram_copier;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [11:0] src;
   logic [11:0] dst;
   logic [11:0] len;
   logic [15:0] fill_val;
   logic        abort;
   logic        busy;
   logic        done;
   logic [11:0] mem_address;
   logic [15:0] mem_in;
   logic        mem_load;
   logic [15:0] mem_out;

   logic [15:0] ram [4096];
   logic        tb_we;
   logic [11:0] tb_addr;
   logic [15:0] tb_data;

   int n_checks;
   int n_pass;
   int n_load;
   int n_done;
   int n_busy;
   int done_cyc;

   ram_copier #(.ADDR_W(12), .DATA_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .mode        (mode),
      .src         (src),
      .dst         (dst),
      .len         (len),
      .fill_val    (fill_val),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .mem_address (mem_address),
      .mem_in      (mem_in),
      .mem_load    (mem_load),
      .mem_out     (mem_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ram4k model: combinational read, clocked write; tb_we is the bench's preload port.
   assign mem_out = ram[mem_address];
   always @(posedge clk) begin
      if (mem_load)
         ram[mem_address] <= mem_in;
      else if (tb_we)
         ram[tb_addr] <= tb_data;
   end

   always @(negedge clk) begin
      if (mem_load) n_load++;
      if (done)     n_done++;
      if (busy)     n_busy++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic poke(input logic [11:0] a, input logic [15:0] d);
      @(negedge clk);
      tb_addr = a;
      tb_data = d;
      tb_we   = 1'b1;
      @(posedge clk);
      #1 tb_we = 1'b0;
   endtask

   // Returns just after accept edge E0; the next negedge is inside cycle 1.
   task automatic start_cmd(input logic m, input logic [11:0] s, input logic [11:0] d,
                            input logic [11:0] l, input logic [15:0] f);
      @(negedge clk);
      n_load   = 0;
      n_done   = 0;
      n_busy   = 0;
      done_cyc = 0;
      mode     = m;
      src      = s;
      dst      = d;
      len      = l;
      fill_val = f;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_load   = 0;
      n_done   = 0;
      n_busy   = 0;
      done_cyc = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      mode     = 1'b0;
      src      = '0;
      dst      = '0;
      len      = '0;
      fill_val = '0;
      abort    = 1'b0;
      tb_we    = 1'b0;
      tb_addr  = '0;
      tb_data  = '0;

      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_load", mem_load, 0);
      check("rst_addr", mem_address, 0);
      check("rst_in",   mem_in, 0);
      rst_n = 1'b1;

      poke(12'h010, 16'hA001);
      poke(12'h011, 16'hA002);
      poke(12'h012, 16'hA003);
      poke(12'h013, 16'hA004);

      // Copy 4 words: busy cycles 1..8, done in cycle 9.
      start_cmd(1'b0, 12'h010, 12'h800, 12'd4, 16'h0);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) check("copy_rd_addr", mem_address, 32'h010);
         if (c == 2) begin
            check("copy_wr_addr", mem_address, 32'h800);
            check("copy_wr_data", mem_in, 32'hA001);
            check("copy_wr_load", mem_load, 1);
         end
         if (done && done_cyc == 0) done_cyc = c;
      end
      check("copy_busy_cycles", n_busy, 8);
      check("copy_done_count", n_done, 1);
      check("copy_done_cycle", done_cyc, 9);
      check("copy_loads", n_load, 4);
      check("copy_w0", ram[12'h800], 32'hA001);
      check("copy_w1", ram[12'h801], 32'hA002);
      check("copy_w2", ram[12'h802], 32'hA003);
      check("copy_w3", ram[12'h803], 32'hA004);

      // Fill across the top of memory.
      poke(12'hFFD, 16'h4444);
      poke(12'h002, 16'h5555);
      start_cmd(1'b1, 12'h000, 12'hFFE, 12'd4, 16'hBEEF);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check("fill_addr_c1", mem_address, 32'hFFE);
            check("fill_load_c1", mem_load, 1);
         end
         if (c == 3) check("fill_addr_wrap", mem_address, 32'h000);
         if (done && done_cyc == 0) done_cyc = c;
      end
      check("fill_loads", n_load, 4);
      check("fill_done_cycle", done_cyc, 5);
      check("fill_done_count", n_done, 1);
      check("fill_ffe", ram[12'hFFE], 32'hBEEF);
      check("fill_fff", ram[12'hFFF], 32'hBEEF);
      check("fill_000", ram[12'h000], 32'hBEEF);
      check("fill_001", ram[12'h001], 32'hBEEF);
      check("fill_002_kept", ram[12'h002], 32'h5555);
      check("fill_ffd_kept", ram[12'hFFD], 32'h4444);

      // len = 0: done in cycle 1, no activity.
      start_cmd(1'b0, 12'h010, 12'h300, 12'd0, 16'h0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (done && done_cyc == 0) done_cyc = c;
      end
      check("len0_done_cycle", done_cyc, 1);
      check("len0_done_count", n_done, 1);
      check("len0_loads", n_load, 0);
      check("len0_busy", n_busy, 0);

      // Second start during a running copy is ignored.
      poke(12'hB00, 16'h6666);
      start_cmd(1'b0, 12'h010, 12'hA00, 12'd4, 16'h0);
      @(negedge clk);
      @(negedge clk);
      mode     = 1'b1;
      src      = 12'h100;
      dst      = 12'hB00;
      len      = 12'd2;
      fill_val = 16'hDEAD;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      check("sb_done_count", n_done, 1);
      check("sb_loads", n_load, 4);
      check("sb_w0", ram[12'hA00], 32'hA001);
      check("sb_w3", ram[12'hA03], 32'hA004);
      check("sb_b00_kept", ram[12'hB00], 32'h6666);

      // Abort in the 3rd WRITE cycle (cycle 6) of an 8-word copy.
      poke(12'hC03, 16'h3333);
      start_cmd(1'b0, 12'h010, 12'hC00, 12'd8, 16'h0);
      repeat (6) @(negedge clk);
      check("abort_in_write", mem_load, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", busy, 0);
      repeat (6) @(negedge clk);
      check("abort_loads", n_load, 3);
      check("abort_no_done", n_done, 0);
      check("abort_w2", ram[12'hC02], 32'hA003);
      check("abort_w3_kept", ram[12'hC03], 32'h3333);

      // Overlapping forward copy replicates the first word.
      poke(12'h100, 16'h1111);
      poke(12'h101, 16'h2222);
      poke(12'h102, 16'h9999);
      start_cmd(1'b0, 12'h100, 12'h101, 12'd2, 16'h0);
      repeat (8) @(negedge clk);
      check("ovl_101", ram[12'h101], 32'h1111);
      check("ovl_102", ram[12'h102], 32'h1111);
      check("ovl_done_count", n_done, 1);

      // Asynchronous reset in the 2nd WRITE cycle of a copy.
      poke(12'h901, 16'h7777);
      start_cmd(1'b0, 12'h010, 12'h900, 12'd4, 16'h0);
      repeat (4) @(negedge clk);
      check("rstmid_pre_load", mem_load, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_busy", busy, 0);
      check("rstmid_done", done, 0);
      check("rstmid_load", mem_load, 0);
      check("rstmid_addr", mem_address, 0);
      check("rstmid_in", mem_in, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      n_load = 0;
      n_done = 0;
      repeat (8) @(negedge clk);
      check("rstmid_no_writes", n_load, 0);
      check("rstmid_no_done", n_done, 0);
      check("rstmid_w0_kept", ram[12'h900], 32'hA001);
      check("rstmid_w1_kept", ram[12'h901], 32'h7777);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_copier.md
# ram_copier

Block-copy and fill engine that initiates transfers on a ram4k-class memory port (12-bit address, 16-bit data, combinational read, write on rising `clk` when load is high). It sits between the control path and a ram4k. It takes a start command with source, destination, length and mode, then drives the memory's `address`/`in`/`load` pins and reads its `out` pin until the block is moved or filled. Command-side handshake is start/busy/done.

## Interface
- `ADDR_W`, 12, memory address width; all pointers wrap modulo 2^ADDR_W
- `DATA_W`, 16, memory word width
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe; sampled only in IDLE
- `mode`  in  1  0 = copy, 1 = fill; latched with `start`
- `src`  in  ADDR_W  copy source base; latched with `start`
- `dst`  in  ADDR_W  destination base; latched with `start`
- `len`  in  ADDR_W  word count, 0..4095; latched with `start`
- `fill_val`  in  DATA_W  fill word; latched with `start`
- `abort`  in  1  cancel the running command
- `busy`  out  1  high in READ/WRITE
- `done`  out  1  one-cycle completion pulse
- `mem_address`  out  ADDR_W  to ram4k `address`
- `mem_in`  out  DATA_W  to ram4k `in`
- `mem_load`  out  1  to ram4k `load`
- `mem_out`  in  DATA_W  from ram4k `out`; combinational read of `mem_address`

## Operation
- Registers: `src_ptr`, `dst_ptr`, `count`, `data`, `mode_r`, and a state register with states IDLE, READ, WRITE, DONE.
- Reset (`rst_n` low, asynchronous): state IDLE, all registers 0. Outputs: busy=0, done=0, mem_load=0, mem_address=0, mem_in=0.
- Output decode (from registered state only):
  - mem_address = `src_ptr` in READ, otherwise `dst_ptr`.
  - mem_in = `data`.
  - mem_load = 1 only in WRITE.
  - busy = 1 in READ or WRITE.
  - done = 1 only in DONE.
- IDLE, `start`=1:
  - Latch `src`, `dst`, `len`, `mode`.
  - If `mode`=1, load `data` with `fill_val`.
  - Next state: `len`=0 → DONE (no memory writes); copy → READ; fill → WRITE.
- READ (copy only): `data` ← `mem_out`. Next state WRITE.
- WRITE:
  - The RAM stores `data` at `dst_ptr` on this edge.
  - `dst_ptr` +1; in copy mode `src_ptr` +1; `count` −1. All arithmetic is ADDR_W bits with wrap (4095+1 = 0).
  - Next state: DONE if `count` was 1; otherwise READ (copy) or WRITE (fill).
- DONE: one cycle, then IDLE. `start` is ignored in DONE.
- `abort`=1 in READ or WRITE: next state IDLE with no done pulse. A write presented in that WRITE cycle still lands, because mem_load is already high. `abort` is ignored in IDLE and DONE.
- `start` while busy is ignored. Inputs may change freely after the accept edge.
- Overlapping copy is strictly forward, word by word. If dst is in (src, src+len), the source pattern replicates; this is the defined behaviour.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- Copy of N≥1 words:
  - busy high from E0 to E(2N).
  - Word k (k = 0..N−1) is read in the cycle after E(2k) and written at edge E(2k+2).
  - done is high in the cycle between E(2N) and E(2N+1).
  - IDLE again after E(2N+1).
- Fill of N words: one write per cycle, at edges E1..EN. done is high after EN; IDLE after E(N+1).
- len=0: busy never rises; done is high in the cycle after E0.
- Minimum spacing between two accepted commands: copy 2N+2 cycles, fill N+2 cycles.
- Asynchronous reset mid-transfer: immediate IDLE, mem_load falls without waiting for a clock edge, no done pulse. Words already written remain in RAM.

## Test plan
- Reset: assert `rst_n`=0 mid-copy → busy, done, mem_load, mem_address and mem_in all 0 at once; no further writes after release.
- Copy: preload RAM[0x010..0x013] = 0xA001..0xA004; copy src=0x010, dst=0x800, len=4 → RAM[0x800..0x803] = 0xA001..0xA004; busy for 8 cycles; done pulses once in cycle 9.
- Fill with wrap: fill_val=0xBEEF, dst=0xFFE, len=4 → RAM[0xFFE], [0xFFF], [0x000], [0x001] = 0xBEEF; 4 consecutive mem_load cycles; RAM[0x002] unchanged.
- len=0 and start-while-busy:
  - len=0 → done in the next cycle, mem_load never high.
  - A second start during a running copy → ignored; first result intact, exactly one done.
- Abort: copy len=8, assert abort in the 3rd WRITE cycle → exactly 3 destination words written, return to IDLE, done never high.
- Overlap: RAM[0x100]=0x1111, RAM[0x101]=0x2222; copy src=0x100, dst=0x101, len=2 → RAM[0x101]=0x1111, RAM[0x102]=0x1111.
